// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - frame-driven 17-slot mux/ADC scan scheduler
// Slot 0 samples a rotating calibration source; slots 1..16 walk the sensor channels.
module mux_scan_sequencer #(
    parameter int SETTLE_CYCLES = 16,
    parameter int ADC_TIMEOUT   = 200,
    parameter int DATA_W        = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frameStrobe,
    input  logic              adcDone,
    input  logic [DATA_W-1:0] adcData,
    output logic              adcStart,
    output logic [2:0]        MxA3,
    output logic [2:0]        MxA12,
    output logic [4:0]        rxAddress,
    output logic [DATA_W-1:0] dataOut,
    output logic              dataValid,
    output logic              scanBusy,
    output logic              adcErr,
    output logic              overrun
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SELECT    = 3'd1;
    localparam logic [2:0] SETTLE    = 3'd2;
    localparam logic [2:0] CONVERT   = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;
    localparam logic [2:0] STORE     = 3'd5;
    localparam logic [2:0] PARK      = 3'd6;

    localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(ADC_TIMEOUT - 1);
    localparam logic [4:0] LAST_SLOT    = 5'd16;
    localparam logic [2:0] MUX_PARKED   = 3'd4;

    logic [2:0]        strobe_q;
    logic [2:0]        state_q, state_d;
    logic [4:0]        slot_q, slot_d;
    logic [1:0]        calib_q, calib_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [2:0]        mxa3_q, mxa3_d;
    logic [2:0]        mxa12_q, mxa12_d;
    logic [4:0]        rx_addr_q, rx_addr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;

    logic              strobe_edge;
    logic [4:0]        slot_m1;
    logic [4:0]        slot_m9;

    assign strobe_edge = strobe_q[1] & ~strobe_q[2];
    assign slot_m1     = slot_q - 5'd1;
    assign slot_m9     = slot_q - 5'd9;

    // Calibration source rotation: gnd, min, gnd, max.
    function automatic logic [2:0] cal_mux(input logic [1:0] c);
        case (c)
            2'd0:    cal_mux = 3'd5;
            2'd1:    cal_mux = 3'd2;
            2'd2:    cal_mux = 3'd5;
            default: cal_mux = 3'd3;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        calib_d    = calib_q;
        cnt_d      = cnt_q;
        mxa3_d     = mxa3_q;
        mxa12_d    = mxa12_q;
        rx_addr_d  = rx_addr_q;
        data_out_d = data_out_q;
        err_d      = err_q;
        busy_d     = busy_q;
        overrun_d  = strobe_edge & (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (strobe_edge) begin
                    slot_d  = 5'd0;
                    busy_d  = 1'b1;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (slot_q == 5'd0) begin
                    mxa3_d = cal_mux(calib_q);
                end else if (slot_q <= 5'd8) begin
                    mxa3_d  = 3'd0;
                    mxa12_d = slot_m1[2:0];
                end else begin
                    mxa3_d  = 3'd1;
                    mxa12_d = slot_m9[2:0];
                end
                cnt_d   = 8'd0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CONVERT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CONVERT: begin
                cnt_d   = 8'd0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Result registers load on entry to STORE so they are valid alongside dataValid.
                if (adcDone) begin
                    data_out_d = adcData;
                    err_d      = 1'b0;
                    rx_addr_d  = slot_q;
                    state_d    = STORE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    data_out_d = {DATA_W{1'b1}};
                    err_d      = 1'b1;
                    rx_addr_d  = slot_q;
                    state_d    = STORE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            STORE: begin
                if (slot_q == LAST_SLOT) begin
                    state_d = PARK;
                end else begin
                    slot_d  = slot_q + 5'd1;
                    state_d = SELECT;
                end
            end
            PARK: begin
                mxa3_d  = MUX_PARKED;
                calib_d = calib_q + 2'd1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_q   <= 3'd0;
            state_q    <= IDLE;
            slot_q     <= 5'd0;
            calib_q    <= 2'd0;
            cnt_q      <= 8'd0;
            mxa3_q     <= MUX_PARKED;
            mxa12_q    <= 3'd0;
            rx_addr_q  <= 5'd0;
            data_out_q <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            strobe_q   <= {strobe_q[1:0], frameStrobe};
            state_q    <= state_d;
            slot_q     <= slot_d;
            calib_q    <= calib_d;
            cnt_q      <= cnt_d;
            mxa3_q     <= mxa3_d;
            mxa12_q    <= mxa12_d;
            rx_addr_q  <= rx_addr_d;
            data_out_q <= data_out_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign adcStart  = (state_q == CONVERT);
    assign dataValid = (state_q == STORE);
    assign adcErr    = (state_q == STORE) & err_q;
    assign MxA3      = mxa3_q;
    assign MxA12     = mxa12_q;
    assign rxAddress = rx_addr_q;
    assign dataOut   = data_out_q;
    assign scanBusy  = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - scoreboard bench for mux_scan_sequencer
// Slot/mux expectations are queued at scan start, data expectations when the ADC model answers.
module tb_mux_scan_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        frameStrobe;
    logic        adcDone;
    logic [11:0] adcData;
    logic        adcStart;
    logic [2:0]  MxA3;
    logic [2:0]  MxA12;
    logic [4:0]  rxAddress;
    logic [11:0] dataOut;
    logic        dataValid;
    logic        scanBusy;
    logic        adcErr;
    logic        overrun;

    always #5 clk = ~clk;

    mux_scan_sequencer #(
        .SETTLE_CYCLES(4),
        .ADC_TIMEOUT  (20),
        .DATA_W       (12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frameStrobe(frameStrobe),
        .adcDone    (adcDone),
        .adcData    (adcData),
        .adcStart   (adcStart),
        .MxA3       (MxA3),
        .MxA12      (MxA12),
        .rxAddress  (rxAddress),
        .dataOut    (dataOut),
        .dataValid  (dataValid),
        .scanBusy   (scanBusy),
        .adcErr     (adcErr),
        .overrun    (overrun)
    );

    typedef struct { int slot; int mxa3; int mxa12; } slot_exp_t;
    typedef struct { logic [11:0] data; logic err; } data_exp_t;

    slot_exp_t   exp_q[$];
    data_exp_t   dat_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cal_m = 0;
    int          m12_m = 0;
    int          cal_tab[4] = '{5, 2, 5, 3};
    int          withhold_slot = -1;
    bit          spur_en = 1'b0;
    int          spur_cd = 0;
    int          done_cd = 0;
    logic [11:0] pend_data;
    int          valid_cnt = 0;
    int          ovr_cnt = 0;
    int          last_start_slot = -1;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_adcStart"}, adcStart, 0);
        check({pfx, "_MxA3"}, MxA3, 4);
        check({pfx, "_MxA12"}, MxA12, 0);
        check({pfx, "_rxAddress"}, rxAddress, 0);
        check({pfx, "_dataOut"}, dataOut, 0);
        check({pfx, "_dataValid"}, dataValid, 0);
        check({pfx, "_scanBusy"}, scanBusy, 0);
        check({pfx, "_adcErr"}, adcErr, 0);
        check({pfx, "_overrun"}, overrun, 0);
    endtask

    task automatic push_scan();
        exp_q.push_back('{0, cal_tab[cal_m], m12_m});
        for (int s = 1; s <= 16; s++) begin
            if (s <= 8) exp_q.push_back('{s, 0, s - 1});
            else        exp_q.push_back('{s, 1, s - 9});
        end
        m12_m = 7;
        cal_m = (cal_m + 1) % 4;
    endtask

    task automatic pulse_strobe();
        @(negedge clk);
        #2 frameStrobe = 1'b1;
        repeat (3) @(negedge clk);
        frameStrobe = 1'b0;
    endtask

    task automatic begin_scan();
        valid_cnt = 0;
        last_start_slot = -1;
        push_scan();
        pulse_strobe();
    endtask

    task automatic wait_scan_end();
        int n;
        n = 0;
        while (!scanBusy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("busy_rise", scanBusy, 1);
        n = 0;
        while (scanBusy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("busy_fall", scanBusy, 0);
        check("park_MxA3", MxA3, 4);
        check("valid_cnt", valid_cnt, 17);
        check("exp_q_drained", exp_q.size(), 0);
    endtask

    task automatic wait_start_slot(input int slot);
        int n;
        n = 0;
        while (last_start_slot < slot && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("wait_start_slot", last_start_slot, slot);
    endtask

    // ADC model and output monitor share one negedge loop so ordering is fixed.
    initial begin
        slot_exp_t e;
        data_exp_t d;
        forever begin
            @(negedge clk);
            adcDone = 1'b0;
            if (reset) begin
                done_cd = 0;
                spur_cd = 0;
            end else begin
                if (overrun) ovr_cnt++;
                if (adcErr && !dataValid) check("adcErr_alone", 1, 0);
                if (dataValid) begin
                    valid_cnt++;
                    if (exp_q.size() == 0 || dat_q.size() == 0) begin
                        check("dv_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        d = dat_q.pop_front();
                        check("rxAddress", rxAddress, e.slot);
                        check("dataOut", dataOut, d.data);
                        check("adcErr", adcErr, d.err);
                        check("store_MxA3", MxA3, e.mxa3);
                        check("store_MxA12", MxA12, e.mxa12);
                        if (spur_en && e.slot == 2) spur_cd = 3;
                    end
                end
                if (adcStart) begin
                    if (exp_q.size() == 0) begin
                        check("start_unexpected", 1, 0);
                    end else begin
                        check("start_MxA3", MxA3, exp_q[0].mxa3);
                        check("start_MxA12", MxA12, exp_q[0].mxa12);
                        last_start_slot = exp_q[0].slot;
                        if (exp_q[0].slot == withhold_slot) begin
                            dat_q.push_back('{12'hFFF, 1'b1});
                        end else begin
                            pend_data = 12'($urandom_range(0, 12'hFFE));
                            if (pend_data == 12'hABC) pend_data = 12'h123;
                            dat_q.push_back('{pend_data, 1'b0});
                            done_cd = 10;
                        end
                    end
                end
                if (spur_cd > 0) begin
                    spur_cd--;
                    if (spur_cd == 0) begin
                        adcDone = 1'b1;
                        adcData = 12'hABC;
                    end
                end
                if (done_cd > 0) begin
                    done_cd--;
                    if (done_cd == 0) begin
                        adcDone = 1'b1;
                        adcData = pend_data;
                    end
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        frameStrobe = 1'b0;
        adcDone     = 1'b0;
        adcData     = 12'h000;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // Single scan, then four more to walk the calibration rotation.
        begin_scan();
        wait_scan_end();
        repeat (4) begin
            begin_scan();
            wait_scan_end();
        end

        // Timeout on slot 7.
        withhold_slot = 7;
        begin_scan();
        wait_scan_end();
        withhold_slot = -1;

        // Extra strobe during slot 3 must be discarded as overrun.
        ovr_cnt = 0;
        begin_scan();
        wait_start_slot(3);
        pulse_strobe();
        wait_scan_end();
        check("overrun_cnt", ovr_cnt, 1);

        // Reset in WAIT_DONE of slot 5.
        begin_scan();
        wait_start_slot(5);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_valid_cnt", valid_cnt, 5);
        check_reset_outputs("midrst");
        exp_q.delete();
        dat_q.delete();
        cal_m = 0;
        m12_m = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_valid_cnt", valid_cnt, 5);
        begin_scan();
        wait_scan_end();

        // Spurious adcDone in SETTLE of slot 3 must be ignored.
        spur_en = 1'b1;
        begin_scan();
        wait_scan_end();
        spur_en = 1'b0;
        check("overrun_total", ovr_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
